// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: forward select codes and hazard FSM state encoding
package pipeline_hazard_ctrl_pkg;
  localparam logic [1:0] FWD_RD    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  typedef enum logic {RUN, FLUSH} state_t;
endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// fwd_select: picks the EX operand source for one source register, EX_MEM winning over MEM_WB
module fwd_select
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] ex_mem_rd,
  input  logic          ex_mem_we,
  input  logic [AW-1:0] mem_wb_rd,
  input  logic          mem_wb_we,
  output logic [1:0]    sel
);
  logic ex_hit, wb_hit;
  assign ex_hit = ex_mem_we && ex_mem_rd != '0 && ex_mem_rd == rs;
  assign wb_hit = mem_wb_we && mem_wb_rd != '0 && mem_wb_rd == rs;
  assign sel    = ex_hit ? FWD_EXMEM : wb_hit ? FWD_MEMWB : FWD_RD;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: forwarding selects, load-use/busy/branch stall-flush control and perf counters
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int BR_FLUSH = 2,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] if_id_rs1,
  input  logic [REG_AW-1:0] if_id_rs2,
  input  logic [REG_AW-1:0] id_ex_rs1,
  input  logic [REG_AW-1:0] id_ex_rs2,
  input  logic [REG_AW-1:0] id_ex_rd,
  input  logic              id_ex_memread,
  input  logic [REG_AW-1:0] ex_mem_rd,
  input  logic              ex_mem_regwrite,
  input  logic [REG_AW-1:0] mem_wb_rd,
  input  logic              mem_wb_regwrite,
  input  logic              ex_busy,
  input  logic              br_taken,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              ex_mem_bubble,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  localparam logic [2:0]       FL_LOAD = 3'(BR_FLUSH - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  state_t     state, state_nx;
  logic [2:0] fl_cnt, fl_nx;
  logic [1:0] fa, fb;
  logic       lu;
  fwd_select #(.AW(REG_AW)) u_fwd_a (
    .rs(id_ex_rs1), .ex_mem_rd(ex_mem_rd), .ex_mem_we(ex_mem_regwrite),
    .mem_wb_rd(mem_wb_rd), .mem_wb_we(mem_wb_regwrite), .sel(fa)
  );
  fwd_select #(.AW(REG_AW)) u_fwd_b (
    .rs(id_ex_rs2), .ex_mem_rd(ex_mem_rd), .ex_mem_we(ex_mem_regwrite),
    .mem_wb_rd(mem_wb_rd), .mem_wb_we(mem_wb_regwrite), .sel(fb)
  );
  assign forward_a = rst_n ? fa : FWD_RD;
  assign forward_b = rst_n ? fb : FWD_RD;
  assign lu = id_ex_memread && id_ex_rd != '0 && (id_ex_rd == if_id_rs1 || id_ex_rd == if_id_rs2);
  always_comb begin
    pc_write      = 1'b0;
    if_id_write   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    state_nx      = state;
    fl_nx         = fl_cnt;
    if (!rst_n) begin
    end else if (ex_busy) begin
      ex_mem_bubble = 1'b1;
    end else if (br_taken) begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      state_nx     = BR_FLUSH > 1 ? FLUSH : RUN;
      fl_nx        = BR_FLUSH > 1 ? FL_LOAD : fl_cnt;
    end else if (state == FLUSH) begin
      // ID holds a flushed NOP here, so a load-use match is spurious
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_id_flush = 1'b1;
      fl_nx       = fl_cnt - 3'd1;
      state_nx    = fl_cnt == 3'd1 ? RUN : FLUSH;
    end else begin
      pc_write     = !lu;
      if_id_write  = !lu;
      id_ex_bubble = lu;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      fl_cnt    <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state  <= state_nx;
      fl_cnt <= fl_nx;
      if (!pc_write && !(&stall_cnt)) stall_cnt <= stall_cnt + ONE;
      if (if_id_flush && !(&flush_cnt)) flush_cnt <= flush_cnt + ONE;
    end
  end
endmodule
